// File: rtl/gate_pkg.sv
// gate_pkg: shared definitions for the pipelined N-input gate reducer.
//   - op encodings (OP_OR .. OP_XNOR; codes 6 and 7 are reserved)
//   - base-function enum used while walking the reduction tree
//   - helpers: base_of, identity, is_inverting, is_reserved
//   - elaboration helpers sizing the tree (level_count, level_offset, latency_of)
package gate_pkg;

  localparam logic [2:0] OP_OR   = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    BASE_OR  = 2'd0,
    BASE_AND = 2'd1,
    BASE_XOR = 2'd2
  } base_e;

  // Function applied inside the tree. Inverting ops share the tree of their
  // non-inverted partner; reserved ops fall back to OR (the result is forced
  // to zero at the last stage anyway).
  function automatic base_e base_of(input logic [2:0] op);
    case (op)
      OP_AND, OP_NAND: return BASE_AND;
      OP_XOR, OP_XNOR: return BASE_XOR;
      default:         return BASE_OR;
    endcase
  endfunction

  // Identity element of the base function, as the fill bit replicated across
  // the operand width by the caller: all-ones for AND, all-zeros for OR/XOR.
  // A missing tree leaf combined with this value leaves the partner unchanged.
  function automatic logic identity(input base_e base);
    return (base == BASE_AND);
  endfunction

  function automatic logic is_inverting(input logic [2:0] op);
    return (op == OP_NOR) || (op == OP_NAND) || (op == OP_XNOR);
  endfunction

  function automatic logic is_reserved(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  // Number of operands alive at tree level lvl (level 0 = the raw inputs).
  function automatic int level_count(input int n, input int lvl);
    int c;
    c = n;
    for (int j = 0; j < lvl; j++) c = (c + 1) / 2;
    return c;
  endfunction

  // Operand offset of tree level lvl inside the flattened level bus.
  function automatic int level_offset(input int n, input int lvl);
    int s;
    s = 0;
    for (int j = 0; j < lvl; j++) s += level_count(n, j);
    return s;
  endfunction

  // Register stages from input accept to output valid.
  function automatic int latency_of(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/gate_reduce_stage.sv
// gate_reduce_stage: one registered level of the reduction tree.
//   Combines operand pairs (2k, 2k+1) with the base function of in_op; an odd
//   last operand is combined with the identity element, i.e. passed through.
//   When FINAL is set (N_IN must be 1 or 2) the stage also applies the output
//   inversion, forces reserved ops to zero and produces err/any flags.
//   All registers hold while advance is low; bubbles shift when it is high.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   advance              pipeline-wide shift enable
//   in_valid/in_op/in_data    beat entering this level (N_IN operands)
//   out_valid/out_op/out_data registered beat leaving (N_OUT operands)
//   out_err, out_any     final-stage flags (constant 0 when FINAL is clear)
module gate_reduce_stage
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N_IN  = 2,
  parameter bit FINAL = 1'b0,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   advance,
  input  logic                   in_valid,
  input  logic [2:0]             in_op,
  input  logic [N_IN*WIDTH-1:0]  in_data,
  output logic                   out_valid,
  output logic [2:0]             out_op,
  output logic [N_OUT*WIDTH-1:0] out_data,
  output logic                   out_err,
  output logic                   out_any
);

  base_e                  base;
  logic [N_OUT*WIDTH-1:0] red;
  logic [N_OUT*WIDTH-1:0] data_d;
  logic                   err_d;
  logic                   any_d;

  function automatic logic [WIDTH-1:0] combine(input base_e b,
                                               input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
    case (b)
      BASE_AND: return x & y;
      BASE_XOR: return x ^ y;
      default:  return x | y;
    endcase
  endfunction

  assign base = base_of(in_op);

  for (genvar k = 0; k < N_OUT; k++) begin : g_pair
    if (2 * k + 1 < N_IN) begin : g_full
      assign red[k*WIDTH +: WIDTH] = combine(base, in_data[2*k*WIDTH +: WIDTH],
                                             in_data[(2*k+1)*WIDTH +: WIDTH]);
    end else begin : g_odd
      assign red[k*WIDTH +: WIDTH] = combine(base, in_data[2*k*WIDTH +: WIDTH],
                                             {WIDTH{identity(base)}});
    end
  end

  if (FINAL) begin : g_final
    // Inversion happens only here so inner levels never need to know about it.
    assign data_d = is_reserved(in_op)  ? '0   :
                    is_inverting(in_op) ? ~red : red;
    // Flags are qualified by valid so a bubble never carries err/any.
    assign err_d  = in_valid & is_reserved(in_op);
    assign any_d  = in_valid & (|data_d);
  end else begin : g_inner
    assign data_d = red;
    assign err_d  = 1'b0;
    assign any_d  = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_op    <= '0;
      out_data  <= '0;
      out_err   <= 1'b0;
      out_any   <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      out_op    <= in_op;
      out_data  <= data_d;
      out_err   <= err_d;
      out_any   <= any_d;
    end
  end

endmodule

// File: rtl/gate_reduce_pipe.sv
// gate_reduce_pipe: pipelined NUM_IN-operand bitwise gate reducer.
//   Reduces NUM_IN operands of WIDTH bits with OR/AND/XOR/NOR/NAND/XNOR chosen
//   per beat by in_op. A registered binary tree of LATENCY levels
//   (max(1, clog2(NUM_IN))) sits between input accept and output valid.
// Handshake: advance = !out_valid | out_ready; in_ready = advance. A beat is
//   taken when in_valid & in_ready and a result leaves when out_valid &
//   out_ready. While advance is low every stage holds, so out_* is stable;
//   while it is high all stages shift, bubbles included, giving one beat per
//   cycle with simultaneous accept and emit.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid, in_ready       input handshake
//   in_data [NUM_IN*WIDTH]   operand k at in_data[k*WIDTH +: WIDTH]
//   in_op [3]                0 OR,1 AND,2 XOR,3 NOR,4 NAND,5 XNOR,6-7 reserved
//   out_valid, out_ready     output handshake
//   out_data [WIDTH]         reduced result (zero for reserved ops)
//   out_err                  beat carried a reserved op
//   out_any                  |out_data, registered, qualified by out_valid
module gate_reduce_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [2:0]              in_op,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_err,
  output logic                    out_any
);

  localparam int LATENCY = latency_of(NUM_IN);
  // All tree levels are packed back to back in one bus: level 0 holds the
  // raw operands, level LATENCY holds the single result operand.
  localparam int TREE_W  = WIDTH * level_offset(NUM_IN, LATENCY + 1);
  localparam int OUT_OFF = WIDTH * level_offset(NUM_IN, LATENCY);

  logic              advance;
  logic [TREE_W-1:0] tree;
  logic [LATENCY:0]  stage_valid;
  logic [2:0]        stage_op [0:LATENCY];
  logic [LATENCY-1:0] stage_err;
  logic [LATENCY-1:0] stage_any;

  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // in_valid feeds the first stage directly: when advance is low the stage
  // holds anyway, so no explicit accept gating is needed.
  assign tree[NUM_IN*WIDTH-1:0] = in_data;
  assign stage_valid[0]         = in_valid;
  assign stage_op[0]            = in_op;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    localparam int NI    = level_count(NUM_IN, i);
    localparam int NO    = level_count(NUM_IN, i + 1);
    localparam int OFF_I = WIDTH * level_offset(NUM_IN, i);
    localparam int OFF_O = WIDTH * level_offset(NUM_IN, i + 1);

    gate_reduce_stage #(
      .WIDTH (WIDTH),
      .N_IN  (NI),
      .FINAL (i == LATENCY - 1)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .advance   (advance),
      .in_valid  (stage_valid[i]),
      .in_op     (stage_op[i]),
      .in_data   (tree[OFF_I +: NI*WIDTH]),
      .out_valid (stage_valid[i+1]),
      .out_op    (stage_op[i+1]),
      .out_data  (tree[OFF_O +: NO*WIDTH]),
      .out_err   (stage_err[i]),
      .out_any   (stage_any[i])
    );
  end

  assign out_valid = stage_valid[LATENCY];
  assign out_data  = tree[OUT_OFF +: WIDTH];
  assign out_err   = stage_err[LATENCY-1];
  assign out_any   = stage_any[LATENCY-1];

  // Op after the last stage and flags of inner stages have no consumer.
  logic unused_sink;
  assign unused_sink = &{1'b0, stage_op[LATENCY], stage_err, stage_any};

endmodule

// File: tb/tb_gate_reduce_pipe.sv
// tb_gate_reduce_pipe: directed bench for gate_reduce_pipe with a NUM_IN=4
// instance (latency 2) and a NUM_IN=3 instance (latency 2, padded tree leaf).
module tb_gate_reduce_pipe;

  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_err4, out_any4;
  logic [31:0] in_data4;
  logic [2:0]  in_op4;
  logic [7:0]  out_data4;

  logic        in_valid3, in_ready3, out_valid3, out_ready3, out_err3, out_any3;
  logic [23:0] in_data3;
  logic [2:0]  in_op3;
  logic [7:0]  out_data3;

  gate_reduce_pipe #(.WIDTH(8), .NUM_IN(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .in_data   (in_data4),
    .in_op     (in_op4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .out_data  (out_data4),
    .out_err   (out_err4),
    .out_any   (out_any4)
  );

  gate_reduce_pipe #(.WIDTH(8), .NUM_IN(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_data   (in_data3),
    .in_op     (in_op3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_any   (out_any3)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s[%0d] got %0h want %0h", name, idx, act, exp);
    else
      n_pass++;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        sel3;      // 1: NUM_IN=3 instance, 0: NUM_IN=4 instance
    logic [2:0]  op;
    logic [31:0] data;      // {op3, op2, op1, op0}
    logic [7:0]  exp_data;
    logic        exp_err;
    logic        exp_any;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [0:NV-1];

  // ---------------- driver tasks ----------------
  task automatic sample(input logic sel3, output logic ov, output logic [7:0] od,
                        output logic oe, output logic oa);
    if (sel3) begin
      ov = out_valid3; od = out_data3; oe = out_err3; oa = out_any3;
    end else begin
      ov = out_valid4; od = out_data4; oe = out_err4; oa = out_any4;
    end
  endtask

  // Send one beat into an idle pipe and check result and exact latency.
  task automatic run_beat(input vec_t v, input int idx);
    int         cycles;
    logic       ov, oe, oa;
    logic [7:0] od;
    @(negedge clk);
    if (v.sel3) begin
      in_valid3 = 1'b1; in_op3 = v.op; in_data3 = v.data[23:0];
    end else begin
      in_valid4 = 1'b1; in_op4 = v.op; in_data4 = v.data;
    end
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
    in_valid4 = 1'b0;
    cycles = 1;
    sample(v.sel3, ov, od, oe, oa);
    while (!ov && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      sample(v.sel3, ov, od, oe, oa);
    end
    check("latency", idx, cycles, LAT);
    check("data",    idx, od, v.exp_data);
    check("err",     idx, oe, v.exp_err);
    check("any",     idx, oa, v.exp_any);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h80_04_02_01, 8'h87, 1'b0, 1'b1}; // OR
    vecs[1]  = '{1'b0, 3'd1, 32'hFF_3C_0F_FF, 8'h0C, 1'b0, 1'b1}; // AND
    vecs[2]  = '{1'b0, 3'd5, 32'h08_04_02_01, 8'hF0, 1'b0, 1'b1}; // XNOR
    vecs[3]  = '{1'b0, 3'd4, 32'hFF_FF_FF_FF, 8'h00, 1'b0, 1'b0}; // NAND
    vecs[4]  = '{1'b0, 3'd7, 32'h12_34_56_78, 8'h00, 1'b1, 1'b0}; // reserved
    vecs[5]  = '{1'b0, 3'd0, 32'h00_00_00_10, 8'h10, 1'b0, 1'b1}; // OR clears err
    vecs[6]  = '{1'b1, 3'd1, 32'h00_F3_FF_F0, 8'hF0, 1'b0, 1'b1}; // AND, pad
    vecs[7]  = '{1'b1, 3'd4, 32'h00_F3_FF_F0, 8'h0F, 1'b0, 1'b1}; // NAND, pad
    vecs[8]  = '{1'b1, 3'd2, 32'h00_F0_00_0F, 8'hFF, 1'b0, 1'b1}; // XOR, pad
    vecs[9]  = '{1'b1, 3'd6, 32'h00_CC_BB_AA, 8'h00, 1'b1, 1'b0}; // reserved
    vecs[10] = '{1'b1, 3'd0, 32'h00_01_00_00, 8'h01, 1'b0, 1'b1}; // odd leaf

    rst = 1'b1;
    in_valid4 = 1'b0; in_op4 = '0; in_data4 = '0; out_ready4 = 1'b1;
    in_valid3 = 1'b0; in_op3 = '0; in_data3 = '0; out_ready3 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 0, out_valid4, 1'b0);
    check("rst_data",  0, out_data4,  8'h00);
    check("rst_err",   0, out_err4,   1'b0);
    check("rst_any",   0, out_any4,   1'b0);
    check("rst_ready", 0, in_ready4,  1'b1);
    check("rst_valid3", 0, out_valid3, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) run_beat(vecs[i], i);

    // Back-to-back NOR then XOR: consecutive results, no bubble.
    @(negedge clk);
    in_valid4 = 1'b1; in_op4 = 3'd3; in_data4 = 32'h80_04_02_01;
    @(posedge clk); #1;
    in_op4 = 3'd2; in_data4 = 32'h00_F0_0F_FF;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    check("b2b_valid0", 0, out_valid4, 1'b1);
    check("b2b_data0",  0, out_data4,  8'h78);
    check("b2b_any0",   0, out_any4,   1'b1);
    @(posedge clk); #1;
    check("b2b_valid1", 1, out_valid4, 1'b1);
    check("b2b_data1",  1, out_data4,  8'h00);
    check("b2b_any1",   1, out_any4,   1'b0);
    check("b2b_err1",   1, out_err4,   1'b0);
    @(posedge clk); #1;
    check("b2b_drain", 0, out_valid4, 1'b0);

    // Backpressure: three beats offered, output stalled for five cycles.
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    @(negedge clk);
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; in_op4 = 3'd0; in_data4 = 32'h00_00_00_11;
    @(posedge clk); #1;
    in_op4 = 3'd1; in_data4 = 32'hFF_FF_FF_22;
    @(posedge clk); #1;
    in_op4 = 3'd2; in_data4 = 32'h00_33_00_00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_in_ready", c, in_ready4,  1'b0);
      check("bp_valid",    c, out_valid4, 1'b1);
      check("bp_data",     c, out_data4,  8'h11);
      @(posedge clk);
    end
    @(negedge clk);
    out_ready4 = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      if (out_valid4) begin
        if (exp_q.size() == 0) begin
          check("bp_extra", c, out_data4, 8'h00);
          n_pass = n_pass; // extra beat already recorded as a failure above
        end else begin
          check("bp_order", c, out_data4, exp_q.pop_front());
        end
      end
      @(posedge clk);
      if (c == 0) begin
        #1;
        in_valid4 = 1'b0;
      end
    end
    check("bp_lost", 0, exp_q.size(), 0);

    // Asynchronous reset with two beats in flight.
    @(negedge clk);
    in_valid4 = 1'b1; in_op4 = 3'd0; in_data4 = 32'h00_00_00_55;
    @(posedge clk); #1;
    in_data4 = 32'h00_00_00_66;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", 0, out_valid4, 1'b0);
    check("arst_data",  0, out_data4,  8'h00);
    check("arst_any",   0, out_any4,   1'b0);
    check("arst_err",   0, out_err4,   1'b0);
    @(negedge clk);
    rst = 1'b0;
    check("arst_ready", 0, in_ready4, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      check("arst_no_ghost", c, out_valid4, 1'b0);
    end
    run_beat('{1'b0, 3'd0, 32'h40_00_20_01, 8'h61, 1'b0, 1'b1}, 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
